// File: rtl/varredura_matriz.sv
// LED matrix row scanner: fetches each row word, shifts it out MSB first, latches it, then lights the row.
// Optional VARREDURA_APAGAMENTO_EN blanks linha_ativa from ENDERECA through TRAVA to avoid ghosting.
module varredura_matriz #(
  parameter int N_LINHAS  = 16,
  parameter int N_COLUNAS = 15,
  parameter int DIV_CLK   = 4,
  parameter int T_EXIBE   = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ativo,
  input  logic [N_COLUNAS-1:0] linha_dados,
  output logic [3:0]           linha_end,
  output logic                 serial_dado,
  output logic                 serial_clk,
  output logic                 serial_latch,
  output logic [N_LINHAS-1:0]  linha_ativa,
  output logic                 fim_frame,
  output logic                 ocupado
);

  localparam int BW = (N_COLUNAS > 1) ? $clog2(N_COLUNAS) : 1;
  localparam int DW = $clog2(2 * DIV_CLK);
  localparam int EW = (T_EXIBE > 1) ? $clog2(T_EXIBE) : 1;

  localparam logic [3:0]    ROW_MAX  = 4'(N_LINHAS - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(N_COLUNAS - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(2 * DIV_CLK - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV_CLK);
  localparam logic [EW-1:0] EXB_MAX  = EW'(T_EXIBE - 1);

  typedef enum logic [2:0] {
    OCIOSO, ENDERECA, CARREGA, DESLOCA, TRAVA, EXIBE, PROXIMA
  } estado_t;

  estado_t                state, next_state;
  logic [3:0]             row_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DW-1:0]          div_cnt;
  logic [EW-1:0]          exb_cnt;
  logic [N_COLUNAS-1:0]   shift_reg;
  logic                   ultima;
  logic                   bit_fim;

  assign ultima      = (row_cnt == ROW_MAX);
  assign bit_fim     = (div_cnt == DIV_MAX);
  assign serial_dado = shift_reg[N_COLUNAS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= OCIOSO;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    ocupado      = (state != OCIOSO);
    serial_clk   = 1'b0;
    serial_latch = 1'b0;
    fim_frame    = 1'b0;
    case (state)
      OCIOSO:   if (ativo) next_state = ENDERECA;
      ENDERECA: next_state = CARREGA;
      CARREGA:  next_state = DESLOCA;
      DESLOCA: begin
        // Low half of each bit period first, so the chain samples a settled bit.
        serial_clk = (div_cnt >= DIV_HALF);
        if (bit_fim && bit_cnt == BIT_MAX) next_state = TRAVA;
      end
      TRAVA: begin
        serial_latch = 1'b1;
        next_state   = EXIBE;
      end
      EXIBE:    if (exb_cnt == EXB_MAX) next_state = PROXIMA;
      PROXIMA: begin
        fim_frame  = ultima;
        next_state = (ultima && !ativo) ? OCIOSO : ENDERECA;
      end
      default:  next_state = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt     <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      exb_cnt     <= '0;
      shift_reg   <= '0;
      linha_end   <= '0;
      linha_ativa <= '0;
    end else begin
      case (state)
        ENDERECA: linha_end <= row_cnt;
        CARREGA: begin
          shift_reg <= linha_dados;
          bit_cnt   <= '0;
          div_cnt   <= '0;
        end
        DESLOCA: begin
          if (bit_fim) begin
            div_cnt   <= '0;
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        TRAVA: begin
          linha_ativa <= N_LINHAS'(1) << row_cnt;
          exb_cnt     <= '0;
        end
        EXIBE: exb_cnt <= exb_cnt + 1'b1;
        PROXIMA: begin
          row_cnt <= ultima ? 4'd0 : row_cnt + 4'd1;
`ifdef VARREDURA_APAGAMENTO_EN
          linha_ativa <= '0;
`endif
          // Leaving for idle restores the reset-time outputs.
          if (ultima && !ativo) begin
            linha_ativa <= '0;
            linha_end   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
